// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (IF) and data (D) requesters.
// Arbitrates, latches the winning command, drives it onto the memory port until the memory
// acknowledges or the timeout expires, then returns a one-cycle ack or err to the owner.
//
// Ports:
//   clkin, rst_in                      clock (rising edge), asynchronous active-high reset
//   if_req_in, if_addr_in              fetch request / address (held until ack or err)
//   if_rdata_out, if_ack_out, if_err_out   fetch read data (held), completion / timeout pulses
//   d_req_in, d_we_in, d_addr_in,
//   d_wdata_in, d_be_in                data request / command (held until ack or err)
//   d_rdata_out, d_ack_out, d_err_out  load data (held), completion / timeout pulses
//   mem_req_out, mem_we_out, mem_addr_out,
//   mem_wdata_out, mem_be_out          latched command to memory, req high for the whole access
//   mem_rdata_in, mem_ack_in           memory read data and completion
module mem_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned MAX_DSTREAK    = 4
) (
  input  logic                clkin,
  input  logic                rst_in,
  input  logic                if_req_in,
  input  logic [ADDR_W-1:0]   if_addr_in,
  output logic [DATA_W-1:0]   if_rdata_out,
  output logic                if_ack_out,
  output logic                if_err_out,
  input  logic                d_req_in,
  input  logic                d_we_in,
  input  logic [ADDR_W-1:0]   d_addr_in,
  input  logic [DATA_W-1:0]   d_wdata_in,
  input  logic [DATA_W/8-1:0] d_be_in,
  output logic [DATA_W-1:0]   d_rdata_out,
  output logic                d_ack_out,
  output logic                d_err_out,
  output logic                mem_req_out,
  output logic                mem_we_out,
  output logic [ADDR_W-1:0]   mem_addr_out,
  output logic [DATA_W-1:0]   mem_wdata_out,
  output logic [DATA_W/8-1:0] mem_be_out,
  input  logic [DATA_W-1:0]   mem_rdata_in,
  input  logic                mem_ack_in
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1) + 1;
  localparam int unsigned STK_W = $clog2(MAX_DSTREAK + 1);
  localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_DSTREAK);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e state_q, state_d;

  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic              owner_d_q, owner_d_d;   // 1: current access belongs to D
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              if_err_q, if_err_d;
  logic              d_ack_q, d_ack_d;
  logic              d_err_q, d_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STK_W-1:0]  dstreak_q, dstreak_d;

  logic any_req;
  logic grant_d;
  logic timeout;

  assign any_req = if_req_in | d_req_in;
  // D wins unless IF is waiting and D has already used up its streak.
  assign grant_d = d_req_in & (~if_req_in | (dstreak_q < STK_MAX));
  // An ack in the same cycle takes priority; see the BUSY branch below.
  assign timeout = TO_EN && (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clkin or posedge rst_in) begin
    if (rst_in) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = StBusy;
      StBusy:  if (mem_ack_in || timeout) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output / datapath next values (all outputs are registered)
  always_comb begin
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    owner_d_d   = owner_d_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    if_err_d    = 1'b0;
    d_ack_d     = 1'b0;
    d_err_d     = 1'b0;
    cnt_d       = cnt_q;
    dstreak_d   = dstreak_q;

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          mem_req_d   = 1'b1;
          owner_d_d   = grant_d;
          mem_we_d    = grant_d & d_we_in;
          mem_addr_d  = grant_d ? d_addr_in : if_addr_in;
          mem_wdata_d = grant_d ? d_wdata_in : '0;
          mem_be_d    = (grant_d && d_we_in) ? d_be_in : '1;
          if (grant_d && if_req_in) begin
            dstreak_d = (dstreak_q == STK_MAX) ? dstreak_q : dstreak_q + STK_W'(1);
          end else begin
            dstreak_d = '0;
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_ack_in) begin
          mem_req_d = 1'b0;
          if (owner_d_q) begin
            d_ack_d = 1'b1;
            if (!mem_we_q) d_rdata_d = mem_rdata_in;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata_in;
          end
        end else if (timeout) begin
          mem_req_d = 1'b0;
          if (owner_d_q) d_err_d = 1'b1;
          else           if_err_d = 1'b1;
        end
      end
      StResp: begin
        cnt_d = '0;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Datapath / output registers
  always_ff @(posedge clkin or posedge rst_in) begin
    if (rst_in) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      owner_d_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      if_err_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      cnt_q       <= '0;
      dstreak_q   <= '0;
    end else begin
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      owner_d_q   <= owner_d_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ack_q    <= if_ack_d;
      if_err_q    <= if_err_d;
      d_ack_q     <= d_ack_d;
      d_err_q     <= d_err_d;
      cnt_q       <= cnt_d;
      dstreak_q   <= dstreak_d;
    end
  end

  assign mem_req_out   = mem_req_q;
  assign mem_we_out    = mem_we_q;
  assign mem_addr_out  = mem_addr_q;
  assign mem_wdata_out = mem_wdata_q;
  assign mem_be_out    = mem_be_q;
  assign if_rdata_out  = if_rdata_q;
  assign if_ack_out    = if_ack_q;
  assign if_err_out    = if_err_q;
  assign d_rdata_out   = d_rdata_q;
  assign d_ack_out     = d_ack_q;
  assign d_err_out     = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: table-driven cycle vectors plus hand-written multi-cycle sequences
// (reset, D-streak fairness, timeout, asynchronous reset mid-access).
module tb_mem_arbiter;

  logic        clkin = 1'b0;
  logic        rst_in;
  logic        if_req_in;
  logic [31:0] if_addr_in;
  logic [31:0] if_rdata_out;
  logic        if_ack_out;
  logic        if_err_out;
  logic        d_req_in;
  logic        d_we_in;
  logic [31:0] d_addr_in;
  logic [31:0] d_wdata_in;
  logic [3:0]  d_be_in;
  logic [31:0] d_rdata_out;
  logic        d_ack_out;
  logic        d_err_out;
  logic        mem_req_out;
  logic        mem_we_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_wdata_out;
  logic [3:0]  mem_be_out;
  logic [31:0] mem_rdata_in;
  logic        mem_ack_in;

  always #5 clkin = ~clkin;

  mem_arbiter #(
    .ADDR_W        (32),
    .DATA_W        (32),
    .TIMEOUT_CYCLES(8),
    .MAX_DSTREAK   (4)
  ) dut (
    .clkin        (clkin),
    .rst_in       (rst_in),
    .if_req_in    (if_req_in),
    .if_addr_in   (if_addr_in),
    .if_rdata_out (if_rdata_out),
    .if_ack_out   (if_ack_out),
    .if_err_out   (if_err_out),
    .d_req_in     (d_req_in),
    .d_we_in      (d_we_in),
    .d_addr_in    (d_addr_in),
    .d_wdata_in   (d_wdata_in),
    .d_be_in      (d_be_in),
    .d_rdata_out  (d_rdata_out),
    .d_ack_out    (d_ack_out),
    .d_err_out    (d_err_out),
    .mem_req_out  (mem_req_out),
    .mem_we_out   (mem_we_out),
    .mem_addr_out (mem_addr_out),
    .mem_wdata_out(mem_wdata_out),
    .mem_be_out   (mem_be_out),
    .mem_rdata_in (mem_rdata_in),
    .mem_ack_in   (mem_ack_in)
  );

  // {req, we, addr, wdata, be, if_ack, if_err, d_ack, d_err, if_rdata, d_rdata}
  typedef logic [137:0] obs_t;

  typedef struct {
    string       name;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    obs_t        exp;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic obs_t ex(logic req, logic we, logic [31:0] addr, logic [31:0] wdata,
                              logic [3:0] be, logic ia, logic ie, logic da, logic de,
                              logic [31:0] ird, logic [31:0] drd);
    return {req, we, addr, wdata, be, ia, ie, da, de, ird, drd};
  endfunction

  function automatic obs_t observe();
    return {mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_be_out,
            if_ack_out, if_err_out, d_ack_out, d_err_out, if_rdata_out, d_rdata_out};
  endfunction

  task automatic chk(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic ir, input logic [31:0] ia, input logic dr,
                     input logic dw, input logic [31:0] da, input logic [31:0] dwd,
                     input logic [3:0] db, input logic ma, input logic [31:0] mrd,
                     input obs_t e);
    vec_t v;
    v.name = name; v.if_req = ir; v.if_addr = ia; v.d_req = dr; v.d_we = dw;
    v.d_addr = da; v.d_wdata = dwd; v.d_be = db; v.mem_ack = ma; v.mem_rdata = mrd;
    v.exp = e;
    vq.push_back(v);
  endtask

  task automatic idle_inputs();
    if_req_in = 1'b0; if_addr_in = '0; d_req_in = 1'b0; d_we_in = 1'b0;
    d_addr_in = '0; d_wdata_in = '0; d_be_in = '0; mem_ack_in = 1'b0; mem_rdata_in = '0;
  endtask

  task automatic step();
    @(posedge clkin);
    @(negedge clkin);
  endtask

  initial begin
    int   n;
    int   hi;
    logic prev;
    logic got[10];

    // Each vector: inputs during one cycle, outputs expected after that cycle's rising edge.
    add("if_grant",     1, 32'h100, 0, 0, 0, 0, 0, 0, 0,
        ex(1, 0, 32'h100, 0, 4'hF, 0, 0, 0, 0, 0, 0));
    add("if_busy",      1, 32'h100, 0, 0, 0, 0, 0, 0, 0,
        ex(1, 0, 32'h100, 0, 4'hF, 0, 0, 0, 0, 0, 0));
    add("if_ack",       1, 32'h100, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF,
        ex(0, 0, 32'h100, 0, 4'hF, 1, 0, 0, 0, 32'hDEADBEEF, 0));
    add("resp_late_ack", 0, 0, 0, 0, 0, 0, 0, 1, 32'h55555555,
        ex(0, 0, 32'h100, 0, 4'hF, 0, 0, 0, 0, 32'hDEADBEEF, 0));
    add("idle_hold",    0, 0, 0, 0, 0, 0, 0, 0, 0,
        ex(0, 0, 32'h100, 0, 4'hF, 0, 0, 0, 0, 32'hDEADBEEF, 0));
    add("both_d_first", 1, 32'h300, 1, 1, 32'h200, 32'h12345678, 4'b0011, 0, 0,
        ex(1, 1, 32'h200, 32'h12345678, 4'b0011, 0, 0, 0, 0, 32'hDEADBEEF, 0));
    add("d_store_ack",  1, 32'h300, 1, 1, 32'h200, 32'h12345678, 4'b0011, 1, 32'hCAFEF00D,
        ex(0, 1, 32'h200, 32'h12345678, 4'b0011, 0, 0, 1, 0, 32'hDEADBEEF, 0));
    add("d_resp_no_grant", 1, 32'h300, 0, 0, 0, 0, 0, 0, 0,
        ex(0, 1, 32'h200, 32'h12345678, 4'b0011, 0, 0, 0, 0, 32'hDEADBEEF, 0));
    add("if_after_d",   1, 32'h300, 0, 0, 0, 0, 0, 0, 0,
        ex(1, 0, 32'h300, 0, 4'hF, 0, 0, 0, 0, 32'hDEADBEEF, 0));
    add("if2_ack",      1, 32'h300, 0, 0, 0, 0, 0, 1, 32'h0BADC0DE,
        ex(0, 0, 32'h300, 0, 4'hF, 1, 0, 0, 0, 32'h0BADC0DE, 0));
    add("if2_resp",     0, 0, 0, 0, 0, 0, 0, 0, 0,
        ex(0, 0, 32'h300, 0, 4'hF, 0, 0, 0, 0, 32'h0BADC0DE, 0));
    add("d_load_grant", 0, 0, 1, 0, 32'h400, 0, 4'b0001, 0, 0,
        ex(1, 0, 32'h400, 0, 4'hF, 0, 0, 0, 0, 32'h0BADC0DE, 0));
    add("d_load_ack",   0, 0, 1, 0, 32'h400, 0, 4'b0001, 1, 32'h11223344,
        ex(0, 0, 32'h400, 0, 4'hF, 0, 0, 1, 0, 32'h0BADC0DE, 32'h11223344));
    add("d_load_resp",  0, 0, 0, 0, 0, 0, 0, 0, 0,
        ex(0, 0, 32'h400, 0, 4'hF, 0, 0, 0, 0, 32'h0BADC0DE, 32'h11223344));

    // Reset held while inputs toggle: every output stays 0.
    rst_in = 1'b1;
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      if_req_in = 1'(i); d_req_in = 1'(i >> 1); d_we_in = 1'b1; mem_ack_in = ~mem_ack_in;
      if_addr_in = $urandom; d_addr_in = $urandom; d_wdata_in = $urandom; d_be_in = 4'hA;
      mem_rdata_in = $urandom;
      step();
      chk("reset_outputs", observe(), '0);
    end
    idle_inputs();
    rst_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_after_reset", 138'(mem_req_out), 138'(0));
    end

    // Table-driven vectors.
    foreach (vq[i]) begin
      if_req_in = vq[i].if_req;  if_addr_in = vq[i].if_addr;
      d_req_in = vq[i].d_req;    d_we_in = vq[i].d_we;       d_addr_in = vq[i].d_addr;
      d_wdata_in = vq[i].d_wdata; d_be_in = vq[i].d_be;
      mem_ack_in = vq[i].mem_ack; mem_rdata_in = vq[i].mem_rdata;
      step();
      chk(vq[i].name, observe(), vq[i].exp);
    end
    idle_inputs();

    // Both requesters held; memory acks the cycle after each grant. Expect D,D,D,D,IF,...
    if_req_in = 1'b1; if_addr_in = 32'h800;
    d_req_in = 1'b1; d_we_in = 1'b1; d_addr_in = 32'h700; d_wdata_in = 32'hA5A5A5A5;
    d_be_in = 4'hF;
    n = 0; prev = 1'b0;
    for (int c = 0; c < 200 && n < 10; c++) begin
      step();
      if (mem_req_out && !prev) begin
        got[n] = mem_we_out;
        n++;
      end
      prev = mem_req_out;
      mem_ack_in = mem_req_out;
    end
    chk("streak_grant_count", 138'(n), 138'(10));
    for (int i = 0; i < n; i++) begin
      chk($sformatf("streak_grant_%0d", i), 138'(got[i]), 138'((i % 5 == 4) ? 0 : 1));
    end
    if_req_in = 1'b0; d_req_in = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      mem_ack_in = mem_req_out;
    end
    idle_inputs();
    step();

    // Memory never acks: mem_req high 8 cycles then a one-cycle d_err.
    d_req_in = 1'b1; d_we_in = 1'b0; d_addr_in = 32'h900; d_be_in = 4'hF;
    hi = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (mem_req_out) hi++;
      else if (hi > 0) break;
    end
    chk("timeout_req_cycles", 138'(hi), 138'(8));
    chk("timeout_err", 138'({if_ack_out, if_err_out, d_ack_out, d_err_out}), 138'(4'b0001));
    d_req_in = 1'b0;
    mem_ack_in = 1'b1; mem_rdata_in = 32'h99;
    step();
    chk("timeout_err_width", 138'({d_err_out, d_ack_out, mem_req_out}), 138'(0));
    step();
    chk("late_ack_ignored", 138'({d_ack_out, mem_req_out, d_rdata_out}),
        138'({2'b00, 32'h11223344}));
    idle_inputs();
    step();

    // Asynchronous reset in BUSY, then a normal fetch.
    d_req_in = 1'b1; d_we_in = 1'b0; d_addr_in = 32'h500; d_be_in = 4'hF;
    step();
    chk("pre_reset_busy", 138'(mem_req_out), 138'(1));
    #2 rst_in = 1'b1;
    #1 chk("async_reset", observe(), '0);
    d_req_in = 1'b0;
    @(negedge clkin);
    rst_in = 1'b0;
    step();
    chk("post_reset_idle", observe(), '0);
    if_req_in = 1'b1; if_addr_in = 32'h600;
    step();
    chk("post_reset_grant", 138'({mem_req_out, mem_we_out, mem_addr_out}),
        138'({2'b10, 32'h600}));
    mem_ack_in = 1'b1; mem_rdata_in = 32'h77;
    step();
    chk("post_reset_ack", 138'({if_ack_out, if_err_out, d_ack_out, d_err_out, if_rdata_out}),
        138'({4'b1000, 32'h77}));
    if_req_in = 1'b0; mem_ack_in = 1'b0;
    step();
    chk("post_reset_ack_pulse", 138'({if_ack_out, mem_req_out}), 138'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
